unsigned_div32by16: RTL and testbench

//   Sequential unsigned divider: 32-bit dividend / 16-bit divisor -> 32-bit quotient + 16-bit remainder.

---
 rtl/fm_arith_pkg.sv | 13 +
 rtl/div_restore_step.sv | 23 ++
 rtl/unsigned_div32by16.sv | 102 ++++++++++
 tb/tb_unsigned_div32by16.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fm_arith_pkg.sv
// Shared arithmetic definitions for the FM ratio/normalisation datapath.
package fm_arith_pkg;

    typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_e;

    localparam int unsigned DIV_DIVIDEND_W = 32;
    localparam int unsigned DIV_DIVISOR_W  = 16;

    function automatic int unsigned div_cnt_w(input int unsigned w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/div_restore_step.sv
// One radix-2 restoring division step: shift in the next dividend bit, trial-subtract divisor.
module div_restore_step #(
    parameter int unsigned DIVISOR_W = 16
) (
    input  logic [DIVISOR_W-1:0] r,
    input  logic                 q_msb,
    input  logic [DIVISOR_W-1:0] d,
    output logic [DIVISOR_W-1:0] r_next,
    output logic                 q_bit
);

    logic [DIVISOR_W:0]   trial;
    logic [DIVISOR_W-1:0] diff;

    // Partial remainder is always < d, so trial < 2d and trial - d fits in DIVISOR_W bits.
    always_comb begin
        trial  = {r, q_msb};
        diff   = DIVISOR_W'(trial - {1'b0, d});
        q_bit  = (trial >= {1'b0, d});
        r_next = q_bit ? diff : trial[DIVISOR_W-1:0];
    end

endmodule

// File: rtl/unsigned_div32by16.sv
// Iterative unsigned divider: one quotient bit per clock, valid/ready on both sides.
module unsigned_div32by16
    import fm_arith_pkg::*;
#(
    parameter int unsigned DIVIDEND_W = DIV_DIVIDEND_W,
    parameter int unsigned DIVISOR_W  = DIV_DIVISOR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int unsigned CntW = div_cnt_w(DIVIDEND_W);
    localparam logic [CntW-1:0] CntLast = CntW'(DIVIDEND_W - 1);

    div_state_e            state;
    logic [CntW-1:0]       cnt;
    logic [DIVIDEND_W-1:0] q_reg;
    logic [DIVISOR_W-1:0]  r_reg;
    logic [DIVISOR_W-1:0]  d_reg;
    logic [DIVISOR_W-1:0]  r_next;
    logic                  q_bit;

    div_restore_step #(
        .DIVISOR_W(DIVISOR_W)
    ) u_step (
        .r      (r_reg),
        .q_msb  (q_reg[DIVIDEND_W-1]),
        .d      (d_reg),
        .r_next (r_next),
        .q_bit  (q_bit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= DIV_IDLE;
            cnt         <= '0;
            q_reg       <= '0;
            r_reg       <= '0;
            d_reg       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            out_valid   <= 1'b0;
            in_ready    <= 1'b0;
        end else begin
            unique case (state)
                DIV_IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        q_reg    <= dividend;
                        r_reg    <= '0;
                        d_reg    <= divisor;
                        cnt      <= CntLast;
                        in_ready <= 1'b0;
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend[DIVISOR_W-1:0];
                            div_by_zero <= 1'b1;
                            out_valid   <= 1'b1;
                            state       <= DIV_DONE;
                        end else begin
                            state <= DIV_RUN;
                        end
                    end
                end
                DIV_RUN: begin
                    // Dividend shifts out of the top while quotient bits shift in at the bottom.
                    q_reg <= {q_reg[DIVIDEND_W-2:0], q_bit};
                    r_reg <= r_next;
                    cnt   <= cnt - 1'b1;
                    if (cnt == '0) begin
                        quotient    <= {q_reg[DIVIDEND_W-2:0], q_bit};
                        remainder   <= r_next;
                        div_by_zero <= 1'b0;
                        out_valid   <= 1'b1;
                        state       <= DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= DIV_IDLE;
                    end
                end
                default: begin
                    state <= DIV_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unsigned_div32by16.sv
// Self-checking bench for unsigned_div32by16 against a plain-arithmetic reference model.
module tb_unsigned_div32by16;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    int checks;
    int errors;
    bit mon_en;
    int n_acc;
    int n_res;

    unsigned_div32by16 dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mon_en) begin
            if (in_valid && in_ready) n_acc++;
            if (out_valid && out_ready) n_res++;
        end
    end

    // Drive one operation from a negedge; returns result and edges from accept to out_valid.
    task automatic run_op(input logic [31:0] a, input logic [15:0] b, input int gap,
                          output logic [31:0] q, output logic [15:0] r, output logic z,
                          output int lat, output bit ok);
        int n;
        ok = 1'b1;
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) ok = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        dividend = $urandom;
        divisor  = 16'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) ok = 1'b0;
        repeat (gap) @(negedge clk);
        q = quotient;
        r = remainder;
        z = div_by_zero;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 0", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got out_valid=%b dbz=%b expected 0 0",
                     out_valid, div_by_zero);
        end
        checks++;
        if (quotient !== 32'd0 || remainder !== 16'd0) begin
            errors++;
            $display("FAIL reset_result: got q=%h r=%h expected 0 0", quotient, remainder);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic [31:0] va [6] = '{32'd100000, 32'hFFFF_FFFF, 32'h1234_5678, 32'd0, 32'd5, 32'd50};
        logic [15:0] vb [6] = '{16'd7, 16'hFFFF, 16'd1, 16'd123, 16'd9, 16'd8};
        logic [31:0] eq [6] = '{32'd14285, 32'h0001_0001, 32'h1234_5678, 32'd0, 32'd0, 32'd6};
        logic [15:0] er [6] = '{16'd5, 16'd0, 16'd0, 16'd0, 16'd5, 16'd2};
        logic [31:0] q;
        logic [15:0] r;
        logic        z;
        int          lat;
        bit          ok;
        for (int i = 0; i < 6; i++) begin
            run_op(va[i], vb[i], i % 3, q, r, z, lat, ok);
            checks++;
            if (!ok || q !== eq[i] || r !== er[i] || z !== 1'b0) begin
                errors++;
                $display("FAIL directed_%0d: got q=%h r=%h dbz=%b expected q=%h r=%h dbz=0",
                         i, q, r, z, eq[i], er[i]);
            end
            checks++;
            if (lat != 33) begin
                errors++;
                $display("FAIL directed_latency_%0d: got %0d expected 33", i, lat);
            end
        end
    endtask

    task automatic test_div_by_zero();
        logic [31:0] q;
        logic [15:0] r;
        logic        z;
        int          lat;
        bit          ok;
        run_op(32'hDEAD_BEEF, 16'd0, 2, q, r, z, lat, ok);
        checks++;
        if (!ok || q !== 32'hFFFF_FFFF || r !== 16'hBEEF || z !== 1'b1) begin
            errors++;
            $display("FAIL div_by_zero: got q=%h r=%h dbz=%b expected q=ffffffff r=beef dbz=1",
                     q, r, z);
        end
        checks++;
        if (lat != 1) begin
            errors++;
            $display("FAIL div_by_zero_latency: got %0d expected 1", lat);
        end
    endtask

    task automatic test_back_to_back();
        int          acc [$];
        int          vld [$];
        logic [31:0] qs [$];
        logic [15:0] rs [$];
        out_ready = 1'b1;
        in_valid  = 1'b1;
        dividend  = 32'd1000;
        divisor   = 16'd3;
        for (int cyc = 0; cyc < 200 && vld.size() < 2; cyc++) begin
            if (in_valid && in_ready) acc.push_back(cyc);
            if (out_valid) begin
                vld.push_back(cyc);
                qs.push_back(quotient);
                rs.push_back(remainder);
            end
            @(negedge clk);
            if (acc.size() == 1) begin
                dividend = 32'd77777;
                divisor  = 16'd10;
            end
            if (acc.size() >= 2) in_valid = 1'b0;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (acc.size() != 2 || vld.size() != 2) begin
            errors++;
            $display("FAIL b2b_count: got accepts=%0d results=%0d expected 2 2",
                     acc.size(), vld.size());
        end else begin
            checks++;
            if (vld[0] - acc[0] != 33 || vld[1] - acc[1] != 33) begin
                errors++;
                $display("FAIL b2b_latency: got %0d %0d expected 33 33",
                         vld[0] - acc[0], vld[1] - acc[1]);
            end
            checks++;
            if (acc[1] - acc[0] != 34 || vld[1] - vld[0] != 34) begin
                errors++;
                $display("FAIL b2b_spacing: got accept gap %0d result gap %0d expected 34 34",
                         acc[1] - acc[0], vld[1] - vld[0]);
            end
            checks++;
            if (qs[0] !== 32'd333 || rs[0] !== 16'd1 || qs[1] !== 32'd7777 || rs[1] !== 16'd7) begin
                errors++;
                $display("FAIL b2b_result: got %0d r%0d, %0d r%0d expected 333 r1, 7777 r7",
                         qs[0], rs[0], qs[1], rs[1]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int n;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        dividend  = 32'd123456789;
        divisor   = 16'd1000;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 32'd123456 ||
                remainder !== 16'd789 || div_by_zero !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_%0d: got v=%b rdy=%b q=%0d r=%0d expected v=1 rdy=0 q=123456 r=789",
                         i, out_valid, in_ready, quotient, remainder);
            end
        end
        in_valid = 1'b1;
        dividend = 32'd5;
        divisor  = 16'd1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || quotient !== 32'd123456 || remainder !== 16'd789) begin
            errors++;
            $display("FAIL bp_ignore_input: got v=%b q=%0d r=%0d expected v=1 q=123456 r=789",
                     out_valid, quotient, remainder);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || quotient !== 32'd123456) begin
            errors++;
            $display("FAIL bp_release: got v=%b rdy=%b q=%0d expected v=0 rdy=1 q=123456",
                     out_valid, in_ready, quotient);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_no_stale_op: got v=%b rdy=%b expected v=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] q;
        logic [15:0] r;
        logic        z;
        int          lat;
        int          n;
        bit          ok;
        bit          seen;
        in_valid = 1'b1;
        dividend = 32'h00AB_CDEF;
        divisor  = 16'h0123;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset_flags: got v=%b rdy=%b dbz=%b expected 0 0 0",
                     out_valid, in_ready, div_by_zero);
        end
        checks++;
        if (quotient !== 32'd0 || remainder !== 16'd0) begin
            errors++;
            $display("FAIL midrun_reset_result: got q=%h r=%h expected 0 0", quotient, remainder);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrun_ready: got %b expected 1", in_ready);
        end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL midrun_no_partial: got out_valid=1 expected 0");
        end
        run_op(32'd50, 16'd8, 0, q, r, z, lat, ok);
        checks++;
        if (!ok || q !== 32'd6 || r !== 16'd2 || z !== 1'b0) begin
            errors++;
            $display("FAIL midrun_next_op: got q=%0d r=%0d dbz=%b expected q=6 r=2 dbz=0", q, r, z);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [15:0] b;
        logic [31:0] q;
        logic [15:0] r;
        logic        z;
        logic [47:0] prod;
        int          lat;
        bit          ok;
        int          kind;
        n_acc  = 0;
        n_res  = 0;
        mon_en = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            kind = int'($urandom_range(0, 7));
            a = $urandom;
            b = 16'($urandom);
            if (kind == 1) b = 16'($urandom_range(1, 255));
            if (kind == 2) begin
                if (b == 16'd0) b = 16'd1;
                a = 32'($urandom_range(0, 32'(b) - 1));
            end
            if (kind == 3) a = 32'($urandom_range(0, 65535));
            if (kind == 7) b = 16'd0;
            else if (b == 16'd0) b = 16'd1;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_op(a, b, int'($urandom_range(0, 3)), q, r, z, lat, ok);
            checks++;
            if (b == 16'd0) begin
                if (!ok || q !== 32'hFFFF_FFFF || r !== a[15:0] || z !== 1'b1) begin
                    errors++;
                    $display("FAIL rand_dbz_%0d: a=%h got q=%h r=%h dbz=%b expected q=ffffffff r=%h dbz=1",
                             i, a, q, r, z, a[15:0]);
                end
            end else begin
                prod = 48'(q) * 48'(b) + 48'(r);
                if (!ok || q !== a / 32'(b) || r !== 16'(a % 32'(b)) || z !== 1'b0 ||
                    prod !== 48'(a) || r >= b || lat != 33) begin
                    errors++;
                    $display("FAIL rand_div_%0d: %h/%h got q=%h r=%h dbz=%b lat=%0d expected q=%h r=%h dbz=0 lat=33",
                             i, a, b, q, r, z, lat, a / 32'(b), 16'(a % 32'(b)));
                end
            end
        end
        @(negedge clk);
        mon_en = 1'b0;
        checks++;
        if (n_acc != n_res || n_acc != 1500) begin
            errors++;
            $display("FAIL rand_one_result_per_accept: got accepts=%0d results=%0d expected 1500 1500",
                     n_acc, n_res);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        mon_en    = 1'b0;
        n_acc     = 0;
        n_res     = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = 32'd0;
        divisor   = 16'd0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_div_by_zero();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
